// File: rtl/wb_spi_target_pkg.sv
// Shared definitions for the SPI-target-to-Wishbone bridge: command codes,
// frame state encoding, bit-counter widths and a small command decode helper.
package wb_spi_target_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  // One counter covers the longest field (a 32-bit word).
  localparam int BIT_CNT_W = 5;

  localparam logic [BIT_CNT_W-1:0] LAST_CMD_BIT   = 5'd7;
  localparam logic [BIT_CNT_W-1:0] LAST_WORD_BIT  = 5'd31;
  localparam logic [BIT_CNT_W-1:0] LAST_DUMMY_BIT = 5'd7;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CMD   = 4'd1,
    ST_ADDR  = 4'd2,
    ST_WDATA = 4'd3,
    ST_WB_WR = 4'd4,
    ST_DUMMY = 4'd5,
    ST_RDATA = 4'd6,
    ST_DONE  = 4'd7,
    ST_SKIP  = 4'd8
  } state_e;

  // True for the only two commands this target understands.
  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin followed by a registered
// rise/fall pulse detector. Pulses appear three clk cycles after the pin edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Synchronise the pin and emit one-cycle pulses on each transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/wb_spi_target.sv
// SPI target (mode 0) that turns each host frame into one 32-bit Wishbone
// read or write. Frame: CMD[8] ADDR[32] then DATA[32] (write, 8'h02) or
// 8 dummy bits followed by 32 read bits on MISO (read, 8'h03).
// Optional bus timeout: define WB_SPI_TARGET_TIMEOUT_EN.
module wb_spi_target
  import wb_spi_target_pkg::*;
#(
`ifdef WB_SPI_TARGET_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 256,
`endif
  parameter logic [31:0] RD_FILL = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk_i,
  input  logic        spi_cs_i,
  input  logic        spi_data_i,
  output logic        spi_data_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        err_o
);

  logic sck_rise_s;
  logic sck_fall_s;
  logic cs_rise_s;
  logic cs_fall_s;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi_clk_i),
    .rise_o  (sck_rise_s),
    .fall_o  (sck_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi_cs_i),
    .rise_o  (cs_rise_s),
    .fall_o  (cs_fall_s)
  );

  // MOSI gets the same three-stage delay as the SCK edge pulses so that the
  // bit seen here is the one present at the rising SCK edge.
  logic mosi_meta_q;
  logic mosi_sync_q;
  logic mosi_q;

  // Synchronise MOSI and align it with the edge pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      mosi_meta_q <= spi_data_i;
      mosi_sync_q <= mosi_meta_q;
      mosi_q      <= mosi_sync_q;
    end
  end

  state_e               state_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [31:0]          shift_q;
  logic [31:0]          rd_sr_q;
  logic                 is_read_q;
  logic                 rd_started_q;
  logic                 cs_high_q;
  logic                 miso_q;
  logic                 cyc_q;
  logic                 we_q;
  logic [3:0]           sel_q;
  logic [31:0]          adr_q;
  logic [31:0]          dat_q;
  logic                 busy_q;
  logic                 err_q;

  logic [31:0] shift_d;
  logic [7:0]  cmd_d;
  logic        timeout_s;
  logic        bus_end_s;
  logic        rd_ack_s;
  logic        rd_late_s;

  assign shift_d = {shift_q[30:0], mosi_q};
  assign cmd_d   = shift_d[7:0];

`ifdef WB_SPI_TARGET_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt_q;

  // Count how long the current bus cycle has waited for an acknowledge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (cyc_q && !wb_ack_i) begin
      to_cnt_q <= to_cnt_q + TO_ONE;
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout_s = cyc_q && !wb_ack_i && (to_cnt_q == TO_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  assign bus_end_s = cyc_q && (wb_ack_i || timeout_s);
  assign rd_ack_s  = cyc_q && wb_ack_i && !we_q;
  // Read data is too late once the first data bit has left on MISO.
  assign rd_late_s = rd_started_q || ((state_q == ST_RDATA) && sck_fall_s);

  // Frame sequencer, Wishbone initiator and MISO driver
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rd_sr_q      <= '0;
      is_read_q    <= 1'b0;
      rd_started_q <= 1'b0;
      cs_high_q    <= 1'b1;
      miso_q       <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'h0;
      adr_q        <= 32'h0000_0000;
      dat_q        <= 32'h0000_0000;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Bus cycle completion, independent of where the frame is.
      if (bus_end_s) begin
        cyc_q  <= 1'b0;
        we_q   <= 1'b0;
        sel_q  <= 4'h0;
        busy_q <= 1'b0;
      end
      if (timeout_s) begin
        err_q <= 1'b1;
      end
      if (rd_ack_s) begin
        if (rd_late_s) begin
          err_q <= 1'b1;
        end else begin
          rd_sr_q <= wb_dat_i;
        end
      end

      if (cs_rise_s) begin
        cs_high_q <= 1'b1;
      end else if (cs_fall_s) begin
        cs_high_q <= 1'b0;
      end

      if (cs_fall_s) begin
        bit_cnt_q    <= '0;
        miso_q       <= 1'b0;
        rd_started_q <= 1'b0;
        if (busy_q || cyc_q) begin
          // Previous bus cycle still outstanding: ignore this frame.
          state_q <= ST_SKIP;
        end else begin
          state_q <= ST_CMD;
          busy_q  <= 1'b1;
          err_q   <= 1'b0;
        end
      end else if (cs_rise_s) begin
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
        if (cyc_q) begin
          // Let the running bus cycle finish before going idle.
          state_q <= ST_DONE;
        end else begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            miso_q <= 1'b0;
          end

          ST_CMD: begin
            if (sck_rise_s) begin
              shift_q <= shift_d;
              if (bit_cnt_q == LAST_CMD_BIT) begin
                bit_cnt_q <= '0;
                if (cmd_known(cmd_d)) begin
                  is_read_q <= (cmd_d == CMD_READ);
                  state_q   <= ST_ADDR;
                end else begin
                  state_q <= ST_SKIP;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          ST_ADDR: begin
            if (sck_rise_s) begin
              shift_q <= shift_d;
              if (bit_cnt_q == LAST_WORD_BIT) begin
                bit_cnt_q <= '0;
                adr_q     <= shift_d;
                if (is_read_q) begin
                  cyc_q        <= 1'b1;
                  we_q         <= 1'b0;
                  sel_q        <= 4'hF;
                  rd_sr_q      <= RD_FILL;
                  rd_started_q <= 1'b0;
                  state_q      <= ST_DUMMY;
                end else begin
                  state_q <= ST_WDATA;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          ST_WDATA: begin
            if (sck_rise_s) begin
              shift_q <= shift_d;
              if (bit_cnt_q == LAST_WORD_BIT) begin
                bit_cnt_q <= '0;
                dat_q     <= shift_d;
                cyc_q     <= 1'b1;
                we_q      <= 1'b1;
                sel_q     <= 4'hF;
                state_q   <= ST_WB_WR;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          ST_WB_WR: begin
            if (!cyc_q) begin
              state_q <= ST_DONE;
            end
          end

          ST_DUMMY: begin
            miso_q <= 1'b0;
            if (sck_rise_s) begin
              if (bit_cnt_q == LAST_DUMMY_BIT) begin
                bit_cnt_q <= '0;
                state_q   <= ST_RDATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          ST_RDATA: begin
            // The first falling edge here ends the last dummy bit and
            // launches data bit 31.
            if (sck_fall_s) begin
              miso_q       <= rd_sr_q[31];
              rd_sr_q      <= {rd_sr_q[30:0], 1'b0};
              rd_started_q <= 1'b1;
            end
            if (sck_rise_s) begin
              if (bit_cnt_q == LAST_WORD_BIT) begin
                bit_cnt_q <= '0;
                state_q   <= ST_DONE;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          ST_DONE: begin
            miso_q <= 1'b0;
            if (cs_high_q && !cyc_q) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end

          ST_SKIP: begin
            miso_q <= 1'b0;
          end

          default: begin
            state_q <= ST_IDLE;
            miso_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_data_o = miso_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_wb_spi_target.sv
// Directed bench for wb_spi_target: SPI host tasks, a Wishbone slave model
// with programmable ack delay, and a bus-protocol monitor.
module tb_wb_spi_target;

  localparam int HALF = 8;  // SCK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk_i = 1'b0;
  logic        spi_cs_i = 1'b1;
  logic        spi_data_i = 1'b0;
  logic        spi_data_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        busy_o;
  logic        err_o;

  int n_vec  = 0;
  int n_miss = 0;

  wb_spi_target dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk_i  (spi_clk_i),
    .spi_cs_i   (spi_cs_i),
    .spi_data_i (spi_data_i),
    .spi_data_o (spi_data_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Wishbone slave model
  logic        slave_en = 1'b1;
  int          ack_delay = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          wait_cnt = 0;
  logic [31:0] cap_adr = 32'h0;
  logic [31:0] cap_dat = 32'h0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = 4'h0;

  always @(negedge clk) begin
    if (wb_cyc_o && slave_en && !wb_ack_i) begin
      if (wait_cnt >= ack_delay) begin
        wb_ack_i <= 1'b1;
        wb_dat_i <= slave_rdata;
        cap_adr  <= wb_adr_o;
        cap_dat  <= wb_dat_o;
        cap_we   <= wb_we_o;
        cap_sel  <= wb_sel_o;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wb_ack_i <= 1'b0;
      wait_cnt <= 0;
    end
  end

  // Count bus cycle starts
  logic cyc_prev = 1'b0;
  int   cyc_starts = 0;
  always @(posedge clk) begin
    cyc_prev <= wb_cyc_o;
    if (wb_cyc_o && !cyc_prev) cyc_starts <= cyc_starts + 1;
  end

  // Protocol monitor: stb mirrors cyc, sel full, adr/dat stable in a cycle
  logic        mon_cyc = 1'b0;
  logic [31:0] mon_adr = 32'h0;
  logic [31:0] mon_dat = 32'h0;
  int          prot_err = 0;
  always @(negedge clk) begin
    mon_cyc <= wb_cyc_o;
    mon_adr <= wb_adr_o;
    mon_dat <= wb_dat_o;
    if (rst_n) begin
      if (wb_stb_o !== wb_cyc_o) prot_err <= prot_err + 1;
      else if (wb_cyc_o && (wb_sel_o !== 4'hF)) prot_err <= prot_err + 1;
      else if (wb_cyc_o && mon_cyc && ((wb_adr_o !== mon_adr) || (wb_dat_o !== mon_dat)))
        prot_err <= prot_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 SPI host: drives bits nbits-1..0 of tx, samples MISO at each rise
  task automatic spi_frame(input logic [79:0] tx, input int nbits, output logic [79:0] rx);
    rx = '0;
    @(negedge clk);
    spi_cs_i = 1'b0;
    wait_clk(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_data_i = tx[i];
      wait_clk(HALF);
      spi_clk_i = 1'b1;
      rx[i] = spi_data_o;
      wait_clk(HALF);
      spi_clk_i = 1'b0;
    end
    wait_clk(HALF);
    spi_cs_i = 1'b1;
    spi_data_i = 1'b0;
    wait_clk(2 * HALF);
  endtask

  logic [79:0] rx;
  int          starts0;

  initial begin
    // Reset state
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(3);
    check("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    check("rst_we", {31'h0, wb_we_o}, 32'h0);
    check("rst_sel", {28'h0, wb_sel_o}, 32'h0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_miso", {31'h0, spi_data_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);

    // 1: write 02/10000000/0000000A
    ack_delay = 1;
    starts0 = cyc_starts;
    spi_frame({8'h00, 8'h02, 32'h1000_0000, 32'h0000_000A}, 72, rx);
    check("wr_starts", cyc_starts - starts0, 32'd1);
    check("wr_adr", cap_adr, 32'h1000_0000);
    check("wr_dat", cap_dat, 32'h0000_000A);
    check("wr_we", {31'h0, cap_we}, 32'h1);
    check("wr_sel", {28'h0, cap_sel}, 32'hF);
    check("wr_busy", {31'h0, busy_o}, 32'h0);
    check("wr_err", {31'h0, err_o}, 32'h0);

    // 2: read 03/80000004, ack after 3 clk
    ack_delay = 3;
    slave_rdata = 32'h1234_5678;
    spi_frame({8'h03, 32'h8000_0004, 8'h00, 32'h0}, 80, rx);
    check("rd_miso", rx[31:0], 32'h1234_5678);
    check("rd_err", {31'h0, err_o}, 32'h0);
    check("rd_adr", cap_adr, 32'h8000_0004);
    check("rd_we", {31'h0, cap_we}, 32'h0);

    // 3: read with ack long after the dummy byte
    ack_delay = 300;
    slave_rdata = 32'h0BAD_CAFE;
    spi_frame({8'h03, 32'h8000_0008, 8'h00, 32'h0}, 80, rx);
    check("late_miso", rx[31:0], 32'hFFFF_FFFF);
    check("late_err", {31'h0, err_o}, 32'h1);
    check("late_busy", {31'h0, busy_o}, 32'h0);

    // 4: CS high after 20 address bits, then a good write
    ack_delay = 2;
    starts0 = cyc_starts;
    spi_frame({52'h0, 8'h02, 20'h20000}, 28, rx);
    check("abort_starts", cyc_starts - starts0, 32'd0);
    check("abort_busy", {31'h0, busy_o}, 32'h0);
    check("abort_err_clr", {31'h0, err_o}, 32'h0);
    spi_frame({8'h00, 8'h02, 32'h2000_0010, 32'hCAFE_F00D}, 72, rx);
    check("post_starts", cyc_starts - starts0, 32'd1);
    check("post_adr", cap_adr, 32'h2000_0010);
    check("post_dat", cap_dat, 32'hCAFE_F00D);

    // 5: unknown command 8'h55
    starts0 = cyc_starts;
    spi_frame({8'h55, 32'hA5A5_A5A5, 8'hFF, 32'hFFFF_FFFF}, 80, rx);
    check("skip_starts", cyc_starts - starts0, 32'd0);
    check("skip_miso", {31'h0, |rx}, 32'h0);
    check("skip_busy", {31'h0, busy_o}, 32'h0);

    // 6: slave never acks
    slave_en = 1'b0;
    spi_frame({8'h00, 8'h02, 32'h3000_0000, 32'h1111_1111}, 72, rx);
    wait_clk(300);
`ifdef WB_SPI_TARGET_TIMEOUT_EN
    check("to_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("to_err", {31'h0, err_o}, 32'h1);
    check("to_busy", {31'h0, busy_o}, 32'h0);
`else
    check("hang_cyc", {31'h0, wb_cyc_o}, 32'h1);
    check("hang_busy", {31'h0, busy_o}, 32'h1);
    check("hang_err", {31'h0, err_o}, 32'h0);
    // A frame started while busy is ignored entirely.
    starts0 = cyc_starts;
    spi_frame({8'h00, 8'h02, 32'h4000_0000, 32'h2222_2222}, 72, rx);
    check("busy_frame_adr", wb_adr_o, 32'h3000_0000);
    check("busy_frame_dat", wb_dat_o, 32'h1111_1111);
    check("busy_frame_starts", cyc_starts - starts0, 32'd0);
    check("busy_frame_cyc", {31'h0, wb_cyc_o}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    wait_clk(1);
    check("rst_drop_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("rst_drop_busy", {31'h0, busy_o}, 32'h0);
    wait_clk(2);
    rst_n = 1'b1;
`endif
    slave_en = 1'b1;
    wait_clk(4);
    check("protocol", prot_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
